pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed IF_ID/ID_EXE/EXE_MEM stage registers.
- Carries one instruction word plus NCH data lanes between adjacent core stages.
- Adds valid/ready flow control, DEPTH-entry skid storage, flush for branch/redirect squash, and NOP bubble insertion when empty.
- One instance goes between each pair of stages in the core.

Parameters:
- DW, 32, width of each data lane.
- IW, 32, instruction word width.
- NCH, 2, number of data lanes (e.g. r1/r2 = 2; alu_out = 1).
- DEPTH, 2, storage entries (legal 1..4; 2 gives full throughput with registered ready).
- NOP_INST, 0, instruction value presented when empty or flushed.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  buffer can accept an entry this cycle.
- in_inst  in  IW  upstream instruction.
- in_data  in  NCH*DW  upstream lanes; lane k at bits [k*DW +: DW].
- flush  in  1  squash all held entries.
- out_valid  out  1  head entry present.
- out_ready  in  1  downstream accepts head.
- out_inst  out  IW  head instruction, or NOP_INST when empty.
- out_data  out  NCH*DW  head lanes, or all zeros when empty.
- count  out  $clog2(DEPTH+1)  occupancy.
- flushed_cnt  out  8  saturating count of valid entries discarded by flush.

Behaviour:
- Reset (async assert, sync-safe release): count=0, out_valid=0, out_inst=NOP_INST, out_data=0, flushed_cnt=0, in_ready=1, read/write pointers=0.
- Storage is a circular FIFO of DEPTH entries holding {inst, data}. Pointers wrap modulo DEPTH; no power-of-two requirement.
- in_ready = (count < DEPTH).
  - Depends only on registered state; there is no combinational path from out_ready to in_ready.
  - When full, a push is refused even if a pop occurs in the same cycle.
- Push: in_valid & in_ready at the clock edge writes the entry at the write pointer.
- Pop: out_valid & out_ready at the clock edge advances the read pointer.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Push into an empty buffer: out_valid goes high the next cycle (latency 1). The data passes through storage; there is no same-cycle bypass.
- out_valid = (count != 0).
- out_inst/out_data show the head entry when valid. When empty they are forced to NOP_INST / 0, so downstream decode sees a bubble.
- Head contents stay stable while out_valid=1 and out_ready=0.
- Flush (sampled at the clock edge):
  - Next state: count=0 and pointers=0.
  - Any push offered in the same cycle is dropped; flush wins over push and pop.
  - flushed_cnt += the pre-flush count, saturating at 255.
- Flush while empty: no effect except that a same-cycle push is discarded.
- Reset mid-operation: all entries are lost immediately (async); outputs show NOP_INST/0 while rst_n is low.
- Underflow and overflow are impossible by construction: pop is gated by out_valid and push by in_ready.
- Held lane bits are never altered; width is exactly NCH*DW with no sign handling.

Test Plan:
- Reset, then in_inst=0x00A30233, in_data={0x5,0x7} with in_valid=1 for 1 cycle, out_ready=1 -> out_valid=1 exactly one cycle later with the same values, then back to out_inst=0, out_data=0, count=0.
- Stream 8 entries with in_valid=1 and out_ready=1 continuously, DEPTH=2 -> one accepted per cycle, outputs in order 1..8, count never exceeds 1 in steady state.
- out_ready=0, push 3 entries -> first two accepted, in_ready=0 after count=2, third held upstream. Raise out_ready -> drains in order 1,2,3 with the head stable while stalled.
- count=2, assert flush together with in_valid=1 -> next cycle count=0, out_inst=NOP_INST, flushed_cnt=2, the pushed entry absent.
- Drop rst_n mid-stream with count=1 -> out_valid=0 and out_inst=NOP_INST asynchronously, before the next clk edge. After release, the first new push appears with 1-cycle latency.
- Configuration sweep DEPTH=3, NCH=1, 300 flushes of a full buffer -> pointer wrap is correct across the non-power-of-two depth, and flushed_cnt saturates at 255.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: a parametrised inter-stage pipeline register with a small skid FIFO.
//
// The buffer carries one instruction word plus NCH data lanes between two adjacent
// core stages. It uses valid/ready flow control and holds up to DEPTH entries.
// A flush squashes every held entry. While the buffer is empty it presents a NOP
// bubble on its outputs.
//
// Ports:
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready    upstream handshake (in_ready depends on registered state only)
//   in_inst, in_data       upstream instruction and lanes (lane k at [k*DW +: DW])
//   flush                  squash all held entries; takes priority over push and pop
//   out_valid / out_ready  downstream handshake on the head entry
//   out_inst, out_data     head entry, or NOP_INST / zeros when empty
//   count                  current occupancy
//   flushed_cnt            saturating count of valid entries discarded by flush
module pipe_stage_buf #(
  parameter int unsigned        DW       = 32,
  parameter int unsigned        IW       = 32,
  parameter int unsigned        NCH      = 2,
  parameter int unsigned        DEPTH    = 2,
  parameter logic [IW-1:0]      NOP_INST = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IW-1:0]              in_inst,
  input  logic [NCH*DW-1:0]          in_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IW-1:0]              out_inst,
  output logic [NCH*DW-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [7:0]                 flushed_cnt
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = NCH * DW;

  logic [IW-1:0] inst_mem [DEPTH];
  logic [LW-1:0] data_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          push;
  logic          pop;
  logic [8:0]    flush_sum;

  // The pointers wrap explicitly at DEPTH-1, so DEPTH does not have to be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // The outputs are forced to a bubble whenever count is zero. Reset clears count
  // asynchronously, so the bubble appears as soon as rst_n falls.
  assign out_inst = out_valid ? inst_mem[rd_ptr] : NOP_INST;
  assign out_data = out_valid ? data_mem[rd_ptr] : '0;

  always_comb begin
    flush_sum = {1'b0, flushed_cnt} + 9'(count);
  end

  // The storage array needs no reset: its contents are never visible while count is 0.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= in_inst;
      data_mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      flushed_cnt <= '0;
    end else if (flush) begin
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      flushed_cnt <= flush_sum[8] ? 8'hFF : flush_sum[7:0];
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

  logic        clk;
  logic        rst_n;

  // Default configuration: DW=32, IW=32, NCH=2, DEPTH=2, NOP_INST=0
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_inst, out_inst;
  logic [63:0] in_data, out_data;
  logic [1:0]  count;
  logic [7:0]  flushed_cnt;

  // Sweep configuration: DW=16, NCH=1, DEPTH=3, NOP_INST=0x13
  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [31:0] b_in_inst, b_out_inst;
  logic [15:0] b_in_data, b_out_data;
  logic [1:0]  b_count;
  logic [7:0]  b_flushed_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_buf #(.DW(32), .IW(32), .NCH(2), .DEPTH(2), .NOP_INST(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_data(out_data),
    .count(count), .flushed_cnt(flushed_cnt)
  );

  pipe_stage_buf #(.DW(16), .IW(32), .NCH(1), .DEPTH(3), .NOP_INST(32'h13)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inst(b_in_inst), .in_data(b_in_data),
    .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_inst(b_out_inst), .out_data(b_out_data),
    .count(b_count), .flushed_cnt(b_flushed_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 0; flush = 0; out_ready = 0; in_inst = '0; in_data = '0;
    b_in_valid = 0; b_flush = 0; b_out_ready = 0; b_in_inst = '0; b_in_data = '0;
    #3;
    n_checks++; if (count !== 2'd0) begin $display("FAIL reset_count: got %0d expected 0", count); n_fail++; end
    n_checks++; if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid: got %b expected 0", out_valid); n_fail++; end
    n_checks++; if (out_inst !== 32'h0) begin $display("FAIL reset_out_inst: got %h expected 0", out_inst); n_fail++; end
    n_checks++; if (out_data !== 64'h0) begin $display("FAIL reset_out_data: got %h expected 0", out_data); n_fail++; end
    n_checks++; if (flushed_cnt !== 8'd0) begin $display("FAIL reset_flushed_cnt: got %0d expected 0", flushed_cnt); n_fail++; end
    n_checks++; if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready: got %b expected 1", in_ready); n_fail++; end
    n_checks++; if (b_out_inst !== 32'h13) begin $display("FAIL reset_b_out_inst: got %h expected 13", b_out_inst); n_fail++; end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin $display("FAIL post_reset_idle: got ready=%b valid=%b expected 1/0", in_ready, out_valid); n_fail++; end
  endtask

  task automatic test_single();
    out_ready = 1; in_valid = 1; in_inst = 32'h00A30233; in_data = {32'h5, 32'h7};
    #1;
    n_checks++; if (out_valid !== 1'b0) begin $display("FAIL single_no_bypass: got %b expected 0", out_valid); n_fail++; end
    step();
    in_valid = 0;
    n_checks++; if (out_valid !== 1'b1) begin $display("FAIL single_valid: got %b expected 1", out_valid); n_fail++; end
    n_checks++; if (out_inst !== 32'h00A30233) begin $display("FAIL single_inst: got %h expected 00a30233", out_inst); n_fail++; end
    n_checks++; if (out_data !== 64'h0000000500000007) begin $display("FAIL single_data: got %h expected 0000000500000007", out_data); n_fail++; end
    n_checks++; if (count !== 2'd1) begin $display("FAIL single_count: got %0d expected 1", count); n_fail++; end
    step();
    n_checks++; if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_data !== 64'h0 || count !== 2'd0)
      begin $display("FAIL single_drained: got v=%b i=%h d=%h c=%0d expected 0/0/0/0", out_valid, out_inst, out_data, count); n_fail++; end
  endtask

  task automatic test_back_to_back();
    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1; in_inst = 32'(i); in_data = {32'(i + 100), 32'(i)};
      step();
      n_checks++; if (out_inst !== 32'(i) || out_data !== {32'(i + 100), 32'(i)})
        begin $display("FAIL stream_head_%0d: got %h/%h expected %h", i, out_inst, out_data, i); n_fail++; end
      n_checks++; if (count !== 2'd1 || in_ready !== 1'b1)
        begin $display("FAIL stream_count_%0d: got count=%0d ready=%b expected 1/1", i, count, in_ready); n_fail++; end
    end
    in_valid = 0;
    step();
    n_checks++; if (count !== 2'd0) begin $display("FAIL stream_drain: got %0d expected 0", count); n_fail++; end
  endtask

  task automatic test_stall();
    out_ready = 0; in_valid = 1;
    in_inst = 32'd1; in_data = {32'd16, 32'd1};
    step();
    n_checks++; if (count !== 2'd1 || in_ready !== 1'b1 || out_inst !== 32'd1)
      begin $display("FAIL stall_push1: got c=%0d r=%b i=%h expected 1/1/1", count, in_ready, out_inst); n_fail++; end
    in_inst = 32'd2; in_data = {32'd32, 32'd2};
    step();
    n_checks++; if (count !== 2'd2 || in_ready !== 1'b0)
      begin $display("FAIL stall_full: got c=%0d r=%b expected 2/0", count, in_ready); n_fail++; end
    in_inst = 32'd3; in_data = {32'd48, 32'd3};
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++; if (count !== 2'd2 || out_inst !== 32'd1 || out_data !== {32'd16, 32'd1})
        begin $display("FAIL stall_hold_%0d: got c=%0d i=%h d=%h expected 2/1", k, count, out_inst, out_data); n_fail++; end
    end
    out_ready = 1;
    step();
    n_checks++; if (count !== 2'd1 || out_inst !== 32'd2 || in_ready !== 1'b1)
      begin $display("FAIL stall_pop1: got c=%0d i=%h r=%b expected 1/2/1", count, out_inst, in_ready); n_fail++; end
    step();
    in_valid = 0;
    n_checks++; if (count !== 2'd1 || out_inst !== 32'd3 || out_data !== {32'd48, 32'd3})
      begin $display("FAIL stall_pop2: got c=%0d i=%h expected 1/3", count, out_inst); n_fail++; end
    step();
    n_checks++; if (count !== 2'd0 || out_valid !== 1'b0)
      begin $display("FAIL stall_drain: got c=%0d v=%b expected 0/0", count, out_valid); n_fail++; end
  endtask

  task automatic test_flush();
    out_ready = 0; in_valid = 1;
    in_inst = 32'h11; in_data = 64'h11; step();
    in_inst = 32'h22; in_data = 64'h22; step();
    n_checks++; if (count !== 2'd2) begin $display("FAIL flush_fill: got %0d expected 2", count); n_fail++; end
    flush = 1; in_inst = 32'h33; in_data = 64'h33;
    step();
    flush = 0; in_valid = 0;
    n_checks++; if (count !== 2'd0 || out_valid !== 1'b0 || out_inst !== 32'h0)
      begin $display("FAIL flush_full: got c=%0d v=%b i=%h expected 0/0/0", count, out_valid, out_inst); n_fail++; end
    n_checks++; if (flushed_cnt !== 8'd2) begin $display("FAIL flush_cnt2: got %0d expected 2", flushed_cnt); n_fail++; end
    in_valid = 1; in_inst = 32'h44; step();
    flush = 1; in_inst = 32'h55; step();
    flush = 0; in_valid = 0;
    n_checks++; if (count !== 2'd0 || flushed_cnt !== 8'd3)
      begin $display("FAIL flush_partial_push: got c=%0d f=%0d expected 0/3", count, flushed_cnt); n_fail++; end
    flush = 1; in_valid = 1; in_inst = 32'h66; step();
    flush = 0; in_valid = 0;
    n_checks++; if (count !== 2'd0 || flushed_cnt !== 8'd3)
      begin $display("FAIL flush_empty: got c=%0d f=%0d expected 0/3", count, flushed_cnt); n_fail++; end
    in_valid = 1; in_inst = 32'h77; in_data = 64'h77; step();
    in_valid = 0;
    n_checks++; if (count !== 2'd1 || out_inst !== 32'h77 || out_data !== 64'h77)
      begin $display("FAIL flush_repush: got c=%0d i=%h expected 1/77", count, out_inst); n_fail++; end
    out_ready = 1; step();
    n_checks++; if (count !== 2'd0) begin $display("FAIL flush_repush_drain: got %0d expected 0", count); n_fail++; end
  endtask

  task automatic test_async_reset();
    out_ready = 0; in_valid = 1; in_inst = 32'h88; in_data = 64'h88;
    step();
    in_valid = 0;
    n_checks++; if (count !== 2'd1) begin $display("FAIL areset_pre: got %0d expected 1", count); n_fail++; end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_data !== 64'h0 || count !== 2'd0)
      begin $display("FAIL areset_async: got v=%b i=%h c=%0d expected 0/0/0", out_valid, out_inst, count); n_fail++; end
    n_checks++; if (flushed_cnt !== 8'd0) begin $display("FAIL areset_flushed: got %0d expected 0", flushed_cnt); n_fail++; end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1; in_inst = 32'h99; in_data = 64'h99; out_ready = 1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin $display("FAIL areset_latency0: got %b expected 0", out_valid); n_fail++; end
    step();
    in_valid = 0;
    n_checks++; if (out_valid !== 1'b1 || out_inst !== 32'h99)
      begin $display("FAIL areset_latency1: got v=%b i=%h expected 1/99", out_valid, out_inst); n_fail++; end
    step();
    n_checks++; if (count !== 2'd0) begin $display("FAIL areset_drain: got %0d expected 0", count); n_fail++; end
  endtask

  task automatic test_sweep();
    int exp_f;
    b_out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      b_in_valid = 1; b_in_inst = 32'h100 + 32'(i); b_in_data = 16'(i + 5);
      step();
      n_checks++; if (b_out_inst !== 32'h100 + 32'(i) || b_out_data !== 16'(i + 5))
        begin $display("FAIL sweep_stream_%0d: got %h/%h expected %h", i, b_out_inst, b_out_data, 32'h100 + 32'(i)); n_fail++; end
    end
    b_in_valid = 0; step();
    n_checks++; if (b_count !== 2'd0 || b_out_inst !== 32'h13 || b_out_data !== 16'h0)
      begin $display("FAIL sweep_bubble: got c=%0d i=%h d=%h expected 0/13/0", b_count, b_out_inst, b_out_data); n_fail++; end
    // Pointers now sit at 2, so this fill wraps through 2,0,1.
    b_out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      b_in_valid = 1; b_in_inst = 32'h201 + 32'(i); b_in_data = 16'hA0 + 16'(i);
      step();
    end
    b_in_valid = 0;
    n_checks++; if (b_count !== 2'd3 || b_in_ready !== 1'b0)
      begin $display("FAIL sweep_full: got c=%0d r=%b expected 3/0", b_count, b_in_ready); n_fail++; end
    b_out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (b_out_inst !== 32'h201 + 32'(i) || b_out_data !== 16'hA0 + 16'(i))
        begin $display("FAIL sweep_wrap_%0d: got %h/%h expected %h", i, b_out_inst, b_out_data, 32'h201 + 32'(i)); n_fail++; end
      step();
    end
    n_checks++; if (b_count !== 2'd0) begin $display("FAIL sweep_wrap_drain: got %0d expected 0", b_count); n_fail++; end
    exp_f = 0;
    b_out_ready = 0;
    for (int k = 0; k < 300; k++) begin
      for (int j = 0; j < 3; j++) begin
        b_in_valid = 1; b_in_inst = 32'(k); b_in_data = 16'(j);
        step();
      end
      n_checks++; if (b_count !== 2'd3) begin $display("FAIL sweep_fill_%0d: got %0d expected 3", k, b_count); n_fail++; end
      b_flush = 1;
      step();
      b_flush = 0; b_in_valid = 0;
      exp_f = (exp_f + 3 > 255) ? 255 : exp_f + 3;
      n_checks++; if (b_flushed_cnt !== 8'(exp_f) || b_count !== 2'd0)
        begin $display("FAIL sweep_flush_%0d: got f=%0d c=%0d expected %0d/0", k, b_flushed_cnt, b_count, exp_f); n_fail++; end
    end
    n_checks++; if (b_flushed_cnt !== 8'd255) begin $display("FAIL sweep_saturate: got %0d expected 255", b_flushed_cnt); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
